// File: rtl/spike_event_logger_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spike_event_logger_pkg
//  Purpose  : Shared constants, record type and serializer state encoding
//             for the spike event logger.
//  Revision : 1.0 - initial release
// ============================================================================
package spike_event_logger_pkg;

    localparam int C_TS_WIDTH   = 14;
    localparam int C_SRC_WIDTH  = 2;
    localparam int C_REC_WIDTH  = C_SRC_WIDTH + C_TS_WIDTH;
    localparam int C_BYTE_WIDTH = 8;

    // Source codes carried in the top two record bits
    localparam logic [C_SRC_WIDTH-1:0] C_SRC_MARKER = 2'b00;
    localparam logic [C_SRC_WIDTH-1:0] C_SRC_PRE    = 2'b01;
    localparam logic [C_SRC_WIDTH-1:0] C_SRC_POST   = 2'b10;
    localparam logic [C_SRC_WIDTH-1:0] C_SRC_BOTH   = 2'b11;

    localparam logic [C_TS_WIDTH-1:0] C_TS_MAX = {C_TS_WIDTH{1'b1}};

    typedef logic [C_REC_WIDTH-1:0] record_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_HI = 2'd1,
        ST_SEND_LO = 2'd2
    } ser_state_t;

    function automatic record_t make_record(input logic [C_SRC_WIDTH-1:0] src,
                                            input logic [C_TS_WIDTH-1:0]  ts);
        return {src, ts};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_event_logger_if.sv
`default_nettype none
// ============================================================================
//  Module   : spike_event_logger_if
//  Purpose  : Byte-stream valid/ready handshake carrying serialized records.
//  Revision : 1.0 - initial release
// ============================================================================
interface spike_event_logger_if;
    import spike_event_logger_pkg::*;

    logic [C_BYTE_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/spike_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : spike_event_fifo
//  Purpose  : Synchronous FIFO with first-word-fall-through read port and
//             occupancy output. Push is refused when full even if a pop
//             happens on the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module spike_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_level
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == C_FULL);
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array write port; contents need no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_event_logger.sv
`default_nettype none
// ============================================================================
//  Module   : spike_event_logger
//  Purpose  : Detects rising edges on pre/post spike inputs, timestamps them
//             into 16-bit records, queues them and serializes each record as
//             two bytes (high then low) on a valid/ready stream.
//  Options  : SPIKE_LOG_WRAP_MARKER_EN - emit a src=00/ts=0 record whenever
//             the timestamp wraps to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module spike_event_logger
    import spike_event_logger_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PRESCALE   = 1
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          i_spike_pre,
    input  wire logic                          i_spike_post,
    spike_event_logger_if.master               out_if,
    output logic                               o_overflow,
    output logic [7:0]                         o_drop_count,
    output logic [$clog2(FIFO_DEPTH):0]        o_fifo_level
);

    localparam logic [7:0] C_PRESC_LAST = 8'(PRESCALE - 1);

    logic                  r_pre_s, r_pre_d, r_post_s, r_post_d;
    logic [7:0]            r_presc;
    logic [C_TS_WIDTH-1:0] r_ts;
    logic                  r_overflow;
    logic [7:0]            r_drop;
    ser_state_t            r_state;
    record_t               r_rec;
    logic [7:0]            r_data;
    logic                  r_valid;

    logic                  w_tick;
    logic                  w_pre_edge, w_post_edge, w_ev_valid;
    record_t               w_ev_rec;
    logic                  w_push;
    record_t               w_push_rec;
    logic [1:0]            w_drops;
    logic [8:0]            w_drop_sum;
    logic                  w_pop;
    record_t               w_head;
    logic                  w_fifo_full, w_fifo_empty;

    assign w_tick      = (r_presc == C_PRESC_LAST);
    assign w_pre_edge  = r_pre_s & ~r_pre_d;
    assign w_post_edge = r_post_s & ~r_post_d;
    assign w_ev_valid  = w_pre_edge | w_post_edge;
    assign w_ev_rec    = make_record({w_post_edge, w_pre_edge}, r_ts);

    // Single sampling stage per input plus its previous-sample history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre_s  <= 1'b0;
            r_pre_d  <= 1'b0;
            r_post_s <= 1'b0;
            r_post_d <= 1'b0;
        end else begin
            r_pre_s  <= i_spike_pre;
            r_pre_d  <= r_pre_s;
            r_post_s <= i_spike_post;
            r_post_d <= r_post_s;
        end
    end

    // Prescaler and free-running wrapping timestamp
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_ts    <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_ts    <= r_ts + C_TS_WIDTH'(1);
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end

`ifdef SPIKE_LOG_WRAP_MARKER_EN
    // Marker wins the single push slot; a displaced spike record waits one
    // cycle in a one-deep skid register and keeps its detection timestamp.
    logic    w_marker;
    logic    r_pend_valid;
    record_t r_pend_rec;
    logic    w_pend_nxt_valid;
    record_t w_pend_nxt_rec;

    assign w_marker = w_tick && (r_ts == C_TS_MAX);

    // Arbitrate marker, skid entry and new event onto the FIFO write port
    always_comb begin
        w_push           = 1'b0;
        w_push_rec       = w_ev_rec;
        w_drops          = 2'd0;
        w_pend_nxt_valid = 1'b0;
        w_pend_nxt_rec   = w_ev_rec;
        if (w_fifo_full) begin
            w_drops = {1'b0, w_marker} + {1'b0, r_pend_valid} + {1'b0, w_ev_valid};
        end else if (w_marker) begin
            w_push     = 1'b1;
            w_push_rec = make_record(C_SRC_MARKER, '0);
            if (w_ev_valid) begin
                w_pend_nxt_valid = 1'b1;
                w_drops          = {1'b0, r_pend_valid};
            end else if (r_pend_valid) begin
                w_pend_nxt_valid = 1'b1;
                w_pend_nxt_rec   = r_pend_rec;
            end
        end else if (r_pend_valid) begin
            w_push           = 1'b1;
            w_push_rec       = r_pend_rec;
            w_pend_nxt_valid = w_ev_valid;
        end else begin
            w_push = w_ev_valid;
        end
    end

    // Skid register for a record displaced by the wrap marker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_rec   <= '0;
        end else begin
            r_pend_valid <= w_pend_nxt_valid;
            r_pend_rec   <= w_pend_nxt_rec;
        end
    end
`else
    // Event goes straight to the FIFO unless it is already full
    always_comb begin
        w_push     = w_ev_valid && !w_fifo_full;
        w_push_rec = w_ev_rec;
        w_drops    = {1'b0, w_ev_valid && w_fifo_full};
    end
`endif

    assign w_drop_sum = {1'b0, r_drop} + {7'd0, w_drops};

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_overflow <= r_overflow | (w_drops != 2'd0);
            r_drop     <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_REC_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (o_fifo_level)
    );

    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_SEND_LO) && out_if.out_ready));

    // Serializer: latch a record on pop, present high byte then low byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rec   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_rec   <= w_head;
                        r_data  <= w_head[C_REC_WIDTH-1 -: 8];
                        r_valid <= 1'b1;
                        r_state <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    if (out_if.out_ready) begin
                        r_data  <= r_rec[7:0];
                        r_state <= ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    if (out_if.out_ready) begin
                        if (!w_fifo_empty) begin
                            r_rec   <= w_head;
                            r_data  <= w_head[C_REC_WIDTH-1 -: 8];
                            r_state <= ST_SEND_HI;
                        end else begin
                            r_data  <= '0;
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_if.out_data  = r_data;
    assign out_if.out_valid = r_valid;
    assign o_overflow       = r_overflow;
    assign o_drop_count     = r_drop;

endmodule
`default_nettype wire

// File: doc/spike_event_logger.md
SPIKE_EVENT_LOGGER -- requirements
Module: spike_event_logger

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, 2..64.
REQ-002 Parameter PRESCALE, default 1, clk cycles per timestamp tick; 1..255.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 spike_pre  input  1  presynaptic neuron spike level.
REQ-006 spike_post  input  1  postsynaptic neuron spike level.
REQ-007 out_data  output  8  serialized event byte.
REQ-008 out_valid  output  1  out_data valid.
REQ-009 out_ready  input  1  consumer accepts byte.
REQ-010 overflow  output  1  sticky; an event was dropped.
REQ-011 drop_count  output  8  dropped-event count, saturating at 255.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 The block SHALL register each spike input once; an event SHALL be a sampled 1 whose previous sample was 0 (rising edge); held levels SHALL produce one event.
REQ-014 Timestamp SHALL be a 14-bit counter incrementing once per PRESCALE cycles, wrapping 16383->0.
REQ-015 Record SHALL be 16 bits {src[1:0], ts[13:0]}; src 01 = pre only, 10 = post only, 11 = both edges in same cycle, 00 = wrap marker.
REQ-016 The record SHALL carry the timestamp value present in the detection cycle and SHALL be written to the FIFO on that clock edge.
REQ-017 Full SHALL be evaluated before any same-cycle pop; an event arriving while full SHALL be dropped, set overflow, and increment drop_count (saturating).
REQ-018 Serializer FSM states IDLE, SEND_HI, SEND_LO; IDLE->SEND_HI when FIFO non-empty (pop and latch record); SEND_HI->SEND_LO on out_valid&&out_ready; SEND_LO->SEND_HI if FIFO non-empty (pop) else IDLE, on out_valid&&out_ready.
REQ-019 out_valid SHALL be 1 exactly in SEND_HI/SEND_LO; out_data = record[15:8] in SEND_HI, record[7:0] in SEND_LO; out_data SHALL stay stable while out_valid&&!out_ready.
REQ-020 Latency: with FSM idle and FIFO empty, high byte SHALL be valid 2 cycles after the detection edge; back-to-back records SHALL stream with no idle cycle when out_ready=1.
REQ-021 fifo_level SHALL reflect push/pop of the previous edge; simultaneous push and pop SHALL leave level unchanged.
REQ-022 In IDLE, out_data SHALL be 8'h00.

Reset
REQ-023 On rst_n=0: FIFO empty, fifo_level=0, FSM IDLE, out_valid=0, out_data=0, overflow=0, drop_count=0, timestamp=0, prescaler=0, spike registers=0.
REQ-024 Reset mid-transfer SHALL abandon the in-flight record without emitting its remaining byte.
REQ-025 A spike input held high through reset release SHALL produce an event on the first active cycle.

Configuration
REQ-026 Macro SPIKE_LOG_WRAP_MARKER_EN: when defined, a src=00 record with ts=0 SHALL be pushed on the cycle the timestamp wraps to 0 (subject to REQ-017; coincident spike edge is pushed as a separate record the following cycle, taking precedence only if marker dropped); when undefined, no marker is generated and src=00 never appears.

Structure
REQ-027 Shared package SHALL hold TS_WIDTH=14, record width 16, src code constants, and the FSM state enum.
REQ-028 FIFO SHALL be a separate sub-module spike_event_fifo (parameterized depth/width, push/pop/full/empty/level).

Verification
REQ-029 Single pre edge at ts=5, out_ready=1 -> bytes 8'h40, 8'h05 on consecutive cycles, high byte 2 cycles after edge.
REQ-030 Pre and post rising same cycle at ts=0x123 -> one record 16'hC123 -> bytes 8'hC1, 8'h23.
REQ-031 out_ready=0, 10 events, FIFO_DEPTH=8 -> fifo_level=8 (one record latched in FSM, 8 stored), 1 dropped, overflow=1, drop_count=1; release out_ready -> 9 records in order, out_data stable while stalled.
REQ-032 PRESCALE=4, spike held high 20 cycles -> exactly one record; ts advances 1 per 4 cycles.
REQ-033 With SPIKE_LOG_WRAP_MARKER_EN, run 16384 ticks -> bytes 8'h00, 8'h00; without macro -> no output.
REQ-034 Assert rst_n after high byte accepted, before low byte -> out_valid=0 next cycle, all counters/flags 0, no low byte emitted.
